calc_ctrl: RTL

Sequencing controller between the Basys-style push-buttons/switches and the shared ALU/opcode encoder of the calculator. It synchronises and debounces all five buttons and turns each btnd press into exactly one ALU operation on a 16-bit accumulator. Sequencing is a 3-state FSM: capture, execute, write-back. It owns the accumulator and LED register, and supplies sign-extended operands to the external alu and debounced button levels to the external calc_enc.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_ctrl_if.sv | 31 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/calc_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
// Holds the FSM encoding, default datapath width and signed-16 saturation helper.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int CALC_WIDTH = 16;

   localparam logic signed [31:0] SAT_MAX = 32'sd32767;
   localparam logic signed [31:0] SAT_MIN = -32'sd32768;

   function automatic logic [15:0] sat16(input logic [31:0] v);
      if ($signed(v) > SAT_MAX) begin
         return SAT_MAX[15:0];
      end else if ($signed(v) < SAT_MIN) begin
         return SAT_MIN[15:0];
      end else begin
         return v[15:0];
      end
   endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Button, switch, encoder, ALU and display signals of the calculator controller.
// slave is the controller side, master the surrounding board/ALU/encoder side.
interface calc_ctrl_if
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
);
   logic             btnc, btnl, btnr, btnu, btnd;
   logic [WIDTH-1:0] sw;
   logic             enc_btnc, enc_btnl, enc_btnr;
   logic [3:0]       enc_alu_op;
   logic [3:0]       alu_op;
   logic [31:0]      alu_op1;
   logic [31:0]      alu_op2;
   logic [31:0]      alu_result;
   logic             alu_zero;
   logic [WIDTH-1:0] led;
   logic             busy, done, zero_flag;

   modport slave (
      input  btnc, btnl, btnr, btnu, btnd, sw, enc_alu_op, alu_result, alu_zero,
      output enc_btnc, enc_btnl, enc_btnr, alu_op, alu_op1, alu_op2,
             led, busy, done, zero_flag
   );

   modport master (
      output btnc, btnl, btnr, btnu, btnd, sw, enc_alu_op, alu_result, alu_zero,
      input  enc_btnc, enc_btnl, enc_btnr, alu_op, alu_op1, alu_op2,
             led, busy, done, zero_flag
   );
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, accepted level and rising-edge pulse.
// The accepted level flips after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_pulse
);
   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1, r_sync2;
   logic          r_level, r_level_d;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: debounced btnd runs one IDLE->EXEC->WRITE ALU operation on the accumulator, btnu clears.
// Define CALC_SAT_EN to saturate the written-back result to signed 16-bit instead of truncating.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH           = CALC_WIDTH,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   calc_ctrl_if.slave  bus
);
   logic w_u_pulse, w_d_pulse;
   logic w_unused_c_pulse, w_unused_l_pulse, w_unused_r_pulse;
   logic w_unused_u_lvl, w_unused_d_lvl;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
      .clk(clk), .rst(rst), .i_btn(bus.btnc), .o_level(bus.enc_btnc), .o_pulse(w_unused_c_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
      .clk(clk), .rst(rst), .i_btn(bus.btnl), .o_level(bus.enc_btnl), .o_pulse(w_unused_l_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
      .clk(clk), .rst(rst), .i_btn(bus.btnr), .o_level(bus.enc_btnr), .o_pulse(w_unused_r_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
      .clk(clk), .rst(rst), .i_btn(bus.btnu), .o_level(w_unused_u_lvl), .o_pulse(w_u_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
      .clk(clk), .rst(rst), .i_btn(bus.btnd), .o_level(w_unused_d_lvl), .o_pulse(w_d_pulse));

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_acc, r_led, r_op2;
   logic [3:0]       r_op;
   logic [31:0]      r_res;
   logic             r_zflag, r_zero_flag;
   logic             w_done;
   logic [WIDTH-1:0] w_wb_val;

`ifdef CALC_SAT_EN
   assign w_wb_val = WIDTH'(sat16(r_res));
`else
   logic w_unused_res_hi;
   assign w_wb_val        = r_res[WIDTH-1:0];
   assign w_unused_res_hi = ^r_res[31:WIDTH];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Clear has priority over every state, so a simultaneous btnd press is simply lost.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      if (w_u_pulse) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_d_pulse) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = WRITE;
            WRITE: begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_led       <= '0;
         r_op2       <= '0;
         r_op        <= '0;
         r_res       <= '0;
         r_zflag     <= 1'b0;
         r_zero_flag <= 1'b0;
      end else if (w_u_pulse) begin
         r_acc       <= '0;
         r_led       <= '0;
         r_zero_flag <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_d_pulse) begin
                  r_op2 <= bus.sw;
                  r_op  <= bus.enc_alu_op;
               end
            end
            EXEC: begin
               r_res   <= bus.alu_result;
               r_zflag <= bus.alu_zero;
            end
            WRITE: begin
               r_acc       <= w_wb_val;
               r_led       <= w_wb_val;
               r_zero_flag <= r_zflag;
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_op    = r_op;
   assign bus.alu_op1   = {{(32-WIDTH){r_acc[WIDTH-1]}}, r_acc};
   assign bus.alu_op2   = {{(32-WIDTH){r_op2[WIDTH-1]}}, r_op2};
   assign bus.led       = r_led;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = w_done;
   assign bus.zero_flag = r_zero_flag;

endmodule
